wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
Multi-precision add sequencer that sits directly upstream of the csa_64 carry-select adder. It accepts one wide operand pair (NUM_WORDS x WORD_W bits) through a valid/ready handshake. It feeds the adder one WORD_W slice per cycle, least-significant slice first, and chains each carry-out into the next slice's carry-in. It then presents the full-width sum and final carry through a valid/ready output handshake.

Parameters:
WORD_W, 64, slice width per adder pass; must match the csa_64 width.
NUM_WORDS, 4, number of slices per operation (>=1); total width TOT_W = WORD_W*NUM_WORDS.

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
in_a  input  TOT_W  operand A
in_b  input  TOT_W  operand B
in_c  input  1  carry-in to the least-significant slice
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  TOT_W  (in_a + in_b + in_c) mod 2^TOT_W
out_c  output  1  bit TOT_W of the full sum
busy  output  1  state != IDLE

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low. All flops clear immediately on rst_n low.
- Reset values: state=IDLE, out_valid=0, out_sum=0, out_c=0, busy=0, slice index=0, carry reg=0. in_ready is forced 0 while rst_n is low.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready at a rising edge: capture in_a/in_b into operand shift regs and in_c into the carry reg, set idx=0, go to RUN.
  - RUN: in_ready=0. The adder sees the low WORD_W of the shift regs plus the carry reg. Each edge does all of the following:
    - write the adder sum into result slot idx;
    - carry reg <= adder c_out;
    - shift operands right by WORD_W;
    - idx++.
  - RUN exit: at the edge where idx==NUM_WORDS-1, go to DONE.
  - DONE: out_valid=1; out_sum = result reg; out_c = carry reg. On out_valid&&out_ready, go to IDLE and drop out_valid.
- Latency: if the accept edge is k, out_valid rises after edge k+NUM_WORDS. Minimum spacing between accepts is NUM_WORDS+2 cycles.
- Backpressure: while in DONE with out_ready=0, out_sum and out_c stay bit-stable. in_valid is ignored while in_ready=0.
- Operands are sampled only at the accept edge. Input changes afterwards have no effect on the result.
- NUM_WORDS=1: RUN lasts exactly one cycle. The idx counter is at least 1 bit wide.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted with no output. After release the block is in IDLE.
- Arithmetic: out_c:out_sum equals the exact (TOT_W+1)-bit sum. There is no overflow flag and no subtraction mode.

Decomposition:
- Shared package: state enum (IDLE, RUN, DONE); localparams TOT_W and IDX_W = max(1, clog2(NUM_WORDS)).
- One sub-module: the existing csa_64 is instantiated as the per-slice datapath.
- The sequencer itself is a single module with no further hierarchy.

Test Plan:
- Carry into next word: NUM_WORDS=4, in_a=2^64-1 (word0 only), in_b=1, in_c=0 -> out_sum=2^64 (word1=1, others 0), out_c=0; out_valid rises exactly 4 cycles after the accept edge.
- Full carry ripple: in_a = all ones (256 bits), in_b=0, in_c=1 -> out_sum=0, out_c=1; with out_ready=1, DONE lasts exactly 1 cycle.
- Small values: in_a=123, in_b=521, in_c=1 -> out_sum=645, out_c=0. Then in_a=851378, in_b=4215, in_c=1 -> out_sum=855594.
- Backpressure: hold out_ready=0 for 10 cycles while in_valid=1 with new operands -> in_ready=0 and out_sum stable throughout. Release out_ready -> IDLE on the next edge, new operands accepted on the following edge, second result correct.
- Reset mid-operation: assert rst_n low after 2 RUN cycles -> out_valid=0, out_sum=0, busy=0 immediately, with no result emitted. A new operation after release gives a correct result.
- Random regression: 500 random in_a/in_b/in_c with random out_ready stalls, checked against a TOT_W+1-bit scoreboard; repeat with NUM_WORDS=1.

Source files
------------

// File: rtl/wide_add_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wide_add_seq_pkg
// Purpose : Shared definitions for the multi-precision add sequencer.
//           Holds the sequencer state encoding, the default geometry and a
//           helper that sizes the slice index counter.
// Ports   : (package, none)
// Rev     : 1.0  initial release
// ============================================================================
package wide_add_seq_pkg;

  // Slice index width: at least one bit even for a single-slice build, so the
  // counter never collapses to a zero-width vector.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Default geometry: four 64-bit slices feeding a 64-bit carry-select adder.
  localparam int DEF_WORD_W    = 64;
  localparam int DEF_NUM_WORDS = 4;
  localparam int TOT_W         = DEF_WORD_W * DEF_NUM_WORDS;
  localparam int IDX_W         = idx_width(DEF_NUM_WORDS);

  // Sequencer states.
  //   IDLE : waiting for an operand pair
  //   RUN  : one adder pass per cycle, least-significant slice first
  //   DONE : result held until the consumer takes it
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

endpackage : wide_add_seq_pkg
`default_nettype wire

// File: rtl/csa_64.sv
`default_nettype none
// ============================================================================
// Module  : csa_64
// Purpose : Carry-select adder. The word is split into BLK_W-bit blocks; each
//           block precomputes its sum for carry-in 0 and carry-in 1, and the
//           incoming block carry selects between them. Purely combinational.
// Ports   : a, b   - WIDTH-bit addends
//           c_in   - carry into bit 0
//           sum    - WIDTH-bit sum
//           c_out  - carry out of bit WIDTH-1
// Rev     : 1.0  initial release
// ============================================================================
module csa_64 #(
  parameter int WIDTH = 64,
  parameter int BLK_W = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NBLK = WIDTH / BLK_W;

  // carry[i] is the carry entering block i; carry[NBLK] leaves the word.
  logic [NBLK:0] carry;

  assign carry[0] = c_in;

  generate
    for (genvar g = 0; g < NBLK; g++) begin : g_blk
      logic [BLK_W-1:0] a_blk;
      logic [BLK_W-1:0] b_blk;
      logic [BLK_W:0]   sum0;   // block result assuming carry-in 0
      logic [BLK_W:0]   sum1;   // block result assuming carry-in 1

      assign a_blk = a[g*BLK_W +: BLK_W];
      assign b_blk = b[g*BLK_W +: BLK_W];

      assign sum0 = {1'b0, a_blk} + {1'b0, b_blk};
      assign sum1 = {1'b0, a_blk} + {1'b0, b_blk} + (BLK_W+1)'(1);

      // Only the late-arriving block carry sits on the select path.
      assign sum[g*BLK_W +: BLK_W] = carry[g] ? sum1[BLK_W-1:0] : sum0[BLK_W-1:0];
      assign carry[g+1]            = carry[g] ? sum1[BLK_W]     : sum0[BLK_W];
    end
  endgenerate

  assign c_out = carry[NBLK];

endmodule : csa_64
`default_nettype wire

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : wide_add_seq
// Purpose : Multi-precision add sequencer. Accepts one NUM_WORDS x WORD_W
//           operand pair, pushes it through a single WORD_W carry-select
//           adder one slice per cycle (LS slice first, carry chained between
//           passes), then offers the full-width sum and final carry.
// Ports   : clk       - clock, rising edge
//           rst_n     - asynchronous active-low reset
//           in_valid  - operand pair valid
//           in_ready  - sequencer can accept operands (IDLE, out of reset)
//           in_a/in_b - TOT_W-bit operands
//           in_c      - carry into the least-significant slice
//           out_valid - result valid (DONE)
//           out_ready - consumer accepts result
//           out_sum   - (in_a + in_b + in_c) mod 2^TOT_W
//           out_c     - bit TOT_W of the full sum
//           busy      - sequencer not IDLE
// Rev     : 1.0  initial release
// ============================================================================
module wide_add_seq
  import wide_add_seq_pkg::*;
#(
  parameter int WORD_W    = DEF_WORD_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WORD_W*NUM_WORDS-1:0] in_a,
  input  logic [WORD_W*NUM_WORDS-1:0] in_b,
  input  logic                        in_c,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W*NUM_WORDS-1:0] out_sum,
  output logic                        out_c,
  output logic                        busy
);

  localparam int TOTAL_W = WORD_W * NUM_WORDS;
  localparam int CNT_W   = idx_width(NUM_WORDS);

  // Index of the final slice; RUN leaves on the edge that processes it.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

  // Carry-select block size: 16-bit blocks when the slice divides evenly,
  // otherwise a single block spanning the slice.
  localparam int CSA_BLK = ((WORD_W % 16) == 0) ? 16 : WORD_W;

  logic [1:0]         state;
  logic [TOTAL_W-1:0] a_sh;      // operand A, consumed from the bottom
  logic [TOTAL_W-1:0] b_sh;      // operand B, consumed from the bottom
  logic               carry;     // carry into the next slice / final carry
  logic [CNT_W-1:0]   idx;       // result slot written this RUN cycle
  logic [TOTAL_W-1:0] result;    // assembled sum

  logic [WORD_W-1:0]  slice_sum;
  logic               slice_c;

  // --------------------------------------------------------------------------
  // Per-slice datapath: the adder always sees the bottom slice of the shift
  // registers, so no wide operand multiplexer is needed.
  // --------------------------------------------------------------------------
  csa_64 #(
    .WIDTH (WORD_W),
    .BLK_W (CSA_BLK)
  ) u_csa (
    .a     (a_sh[WORD_W-1:0]),
    .b     (b_sh[WORD_W-1:0]),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_c)
  );

  // --------------------------------------------------------------------------
  // Handshake and status outputs
  // --------------------------------------------------------------------------
  // rst_n is folded in so upstream never sees a ready while reset is held.
  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = result;
  assign out_c     = carry;

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sh  <= in_a;
            b_sh  <= in_b;
            carry <= in_c;
            idx   <= '0;
            state <= RUN;
          end
        end

        RUN: begin
          result[int'(idx)*WORD_W +: WORD_W] <= slice_sum;
          carry <= slice_c;
          // Shifting brings the next slice down to the adder inputs; the
          // vacated upper bits are never consumed.
          a_sh  <= a_sh >> WORD_W;
          b_sh  <= b_sh >> WORD_W;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end
        end

        DONE: begin
          // result and carry are not written here, so they stay bit-stable
          // for as long as the consumer stalls.
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : wide_add_seq
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_wide_add_seq
// Purpose : Self-checking bench for wide_add_seq. Two instances are exercised
//           in parallel: a 4 x 64-bit build (directed cases, then random) and
//           a 1 x 64-bit build (random). A cycle-level behavioural model per
//           instance predicts handshake timing and the exact wide sum.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wide_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- 4-slice instance ----------------
  logic         rst_n4, in_valid4, in_ready4, in_c4, out_valid4, out_ready4, out_c4, busy4;
  logic [255:0] in_a4, in_b4, out_sum4;

  wide_add_seq #(.WORD_W(64), .NUM_WORDS(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_c(in_c4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_sum(out_sum4), .out_c(out_c4), .busy(busy4)
  );

  // ---------------- 1-slice instance ----------------
  logic         rst_n1, in_valid1, in_ready1, in_c1, out_valid1, out_ready1, out_c1, busy1;
  logic [63:0]  in_a1, in_b1, out_sum1;

  wide_add_seq #(.WORD_W(64), .NUM_WORDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_c(in_c1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_sum(out_sum1), .out_c(out_c1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural models ----------------
  // m_left: cycles of computation remaining; m_valid: result on offer;
  // m_exp: exact (TOT_W+1)-bit sum captured at the accept edge.
  int           m_left4, m_left1;
  logic         m_valid4, m_valid1;
  logic [256:0] m_exp4;
  logic [64:0]  m_exp1;

  always @(posedge clk or negedge rst_n4) begin
    if (!rst_n4) begin
      m_left4 <= 0; m_valid4 <= 1'b0; m_exp4 <= '0;
    end else if (m_left4 != 0) begin
      m_left4 <= m_left4 - 1;
      if (m_left4 == 1) m_valid4 <= 1'b1;
    end else if (m_valid4) begin
      if (out_ready4) m_valid4 <= 1'b0;
    end else if (in_valid4) begin
      m_exp4  <= {1'b0, in_a4} + {1'b0, in_b4} + 257'(in_c4);
      m_left4 <= 4;
    end
  end

  always @(posedge clk or negedge rst_n1) begin
    if (!rst_n1) begin
      m_left1 <= 0; m_valid1 <= 1'b0; m_exp1 <= '0;
    end else if (m_left1 != 0) begin
      m_left1 <= m_left1 - 1;
      if (m_left1 == 1) m_valid1 <= 1'b1;
    end else if (m_valid1) begin
      if (out_ready1) m_valid1 <= 1'b0;
    end else if (in_valid1) begin
      m_exp1  <= {1'b0, in_a1} + {1'b0, in_b1} + 65'(in_c1);
      m_left1 <= 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n4) begin
      chk("rst4_in_ready", 257'(in_ready4), 257'd0);
      chk("rst4_out_valid", 257'(out_valid4), 257'd0);
      chk("rst4_busy", 257'(busy4), 257'd0);
      chk("rst4_out_sum", 257'(out_sum4), 257'd0);
      chk("rst4_out_c", 257'(out_c4), 257'd0);
    end else begin
      chk("in_ready4", 257'(in_ready4), 257'(m_left4 == 0 && !m_valid4));
      chk("out_valid4", 257'(out_valid4), 257'(m_valid4));
      chk("busy4", 257'(busy4), 257'(m_left4 != 0 || m_valid4));
      if (m_valid4) begin
        chk("out_sum4", 257'(out_sum4), 257'(m_exp4[255:0]));
        chk("out_c4", 257'(out_c4), 257'(m_exp4[256]));
      end
    end
    if (!rst_n1) begin
      chk("rst1_in_ready", 257'(in_ready1), 257'd0);
      chk("rst1_out_valid", 257'(out_valid1), 257'd0);
      chk("rst1_out_sum", 257'(out_sum1), 257'd0);
    end else begin
      chk("in_ready1", 257'(in_ready1), 257'(m_left1 == 0 && !m_valid1));
      chk("out_valid1", 257'(out_valid1), 257'(m_valid1));
      chk("busy1", 257'(busy1), 257'(m_left1 != 0 || m_valid1));
      if (m_valid1) begin
        chk("out_sum1", 257'(out_sum1), 257'(m_exp1[63:0]));
        chk("out_c1", 257'(out_c1), 257'(m_exp1[64]));
      end
    end
  end

  // ---------------- random consumer stalls ----------------
  logic rnd_en4 = 1'b0, rnd_en1 = 1'b0;
  initial forever begin
    @(negedge clk);
    if (rnd_en4) out_ready4 = ($urandom_range(0, 3) != 0);
    if (rnd_en1) out_ready1 = ($urandom_range(0, 2) != 0);
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 5))
      0: r = '1;
      1: r = '0;
      2: r = r & {192'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      default: ;
    endcase
    return r;
  endfunction

  // ---------------- drivers ----------------
  // Returns #1 after the accept edge, with inputs scrambled so any late
  // sampling by the DUT would corrupt the result.
  task automatic send4(input logic [255:0] a, input logic [255:0] b, input logic c);
    int n;
    @(negedge clk);
    in_valid4 = 1'b1; in_a4 = a; in_b4 = b; in_c4 = c;
    n = 0;
    while (!in_ready4 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send4_timeout", 257'(n), 257'd0);
    @(posedge clk); #1;
    in_valid4 = 1'b0; in_a4 = rnd256(); in_b4 = rnd256(); in_c4 = 1'($urandom);
  endtask

  task automatic wait4(output int lat);
    lat = 0;
    while (!out_valid4 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic send1(input logic [63:0] a, input logic [63:0] b, input logic c);
    int n;
    @(negedge clk);
    in_valid1 = 1'b1; in_a1 = a; in_b1 = b; in_c1 = c;
    n = 0;
    while (!in_ready1 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("send1_timeout", 257'(n), 257'd0);
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_a1 = {$urandom, $urandom}; in_b1 = {$urandom, $urandom}; in_c1 = 1'($urandom);
  endtask

  task automatic wait1(output int lat);
    lat = 0;
    while (!out_valid1 && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  // ---------------- 4-slice sequence ----------------
  task automatic seq4();
    int lat, n;
    rst_n4 = 1'b0; in_valid4 = 1'b0; in_a4 = '0; in_b4 = '0; in_c4 = 1'b0; out_ready4 = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n4 = 1'b1;

    // Carry from word 0 into word 1
    send4(256'hFFFF_FFFF_FFFF_FFFF, 256'd1, 1'b0);
    wait4(lat);
    chk("carry_word_latency", 257'(lat), 257'd4);
    chk("carry_word_sum", 257'(out_sum4), 257'h1_0000_0000_0000_0000);
    chk("carry_word_c", 257'(out_c4), 257'd0);

    // Full ripple through all slices
    send4('1, '0, 1'b1);
    wait4(lat);
    chk("ripple_sum", 257'(out_sum4), 257'd0);
    chk("ripple_c", 257'(out_c4), 257'd1);
    @(posedge clk); #1;
    chk("ripple_done_one_cycle", 257'(out_valid4), 257'd0);

    // Small values
    send4(256'd123, 256'd521, 1'b1);
    wait4(lat);
    chk("small_a_sum", 257'(out_sum4), 257'd645);
    send4(256'd851378, 256'd4215, 1'b1);
    wait4(lat);
    chk("small_b_sum", 257'(out_sum4), 257'd855594);
    chk("small_b_c", 257'(out_c4), 257'd0);

    // Backpressure with a waiting operand pair
    @(posedge clk); #1;
    out_ready4 = 1'b0;
    send4(256'd1000, 256'd2000, 1'b0);
    wait4(lat);
    chk("bp_latency", 257'(lat), 257'd4);
    @(negedge clk);
    in_valid4 = 1'b1; in_a4 = 256'd7; in_b4 = 256'd8; in_c4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 257'(in_ready4), 257'd0);
      chk("bp_sum_stable", 257'(out_sum4), 257'd3000);
      chk("bp_c_stable", 257'(out_c4), 257'd0);
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle_after_release", 257'(in_ready4), 257'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    chk("bp_second_accepted", 257'(busy4), 257'd1);
    wait4(lat);
    chk("bp_second_latency", 257'(lat), 257'd4);
    chk("bp_second_sum", 257'(out_sum4), 257'd16);

    // Reset after two RUN cycles
    send4(256'h1234, 256'h4321, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n4 = 1'b0;
    #1;
    chk("midrst_out_valid", 257'(out_valid4), 257'd0);
    chk("midrst_out_sum", 257'(out_sum4), 257'd0);
    chk("midrst_busy", 257'(busy4), 257'd0);
    repeat (2) @(posedge clk);
    #2 rst_n4 = 1'b1;
    send4({64'd5, 192'd0}, {64'd6, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0}, 1'b1);
    wait4(lat);
    chk("post_rst_latency", 257'(lat), 257'd4);
    chk("post_rst_sum", 257'(out_sum4), {1'b0, 64'd11, 64'hFFFF_FFFF_FFFF_FFFF, 127'd0, 1'b1});

    // Random regression
    rnd_en4 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send4(rnd256(), rnd256(), 1'($urandom));
    end
    rnd_en4 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; out_ready4 = 1'b1; n++; end
    while (!(m_left4 == 0 && !m_valid4) && n < 200);
    if (n >= 200) chk("drain4_timeout", 257'(n), 257'd0);
  endtask

  // ---------------- 1-slice sequence ----------------
  task automatic seq1();
    int lat, n;
    rst_n1 = 1'b0; in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_c1 = 1'b0; out_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n1 = 1'b1;

    send1(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
    wait1(lat);
    chk("nw1_latency", 257'(lat), 257'd1);
    chk("nw1_ripple_sum", 257'(out_sum1), 257'd0);
    chk("nw1_ripple_c", 257'(out_c1), 257'd1);
    send1(64'd123, 64'd521, 1'b1);
    wait1(lat);
    chk("nw1_small_sum", 257'(out_sum1), 257'd645);

    rnd_en1 = 1'b1;
    for (int i = 0; i < 500; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: send1('1, {$urandom, $urandom}, 1'($urandom));
        default: send1({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      endcase
    end
    rnd_en1 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; out_ready1 = 1'b1; n++; end
    while (!(m_left1 == 0 && !m_valid1) && n < 200);
    if (n >= 200) chk("drain1_timeout", 257'(n), 257'd0);
  endtask

  initial begin
    fork
      seq4();
      seq1();
    join
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, vectors %0d miscompares %0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_wide_add_seq
`default_nettype wire
